// File: rtl/uart_rx.sv
// uart_rx: 8O1 UART receiver with mid-bit sampling, level-held Receive/ReceiveAck handshake
// and parity, framing and overrun status.
module uart_rx #(
    parameter int CLK_FREQ  = 100_000_000,
    parameter int BAUD_RATE = 19_200
) (
    input  logic       clk,
    input  logic       Reset,
    input  logic       Sin,
    input  logic       ReceiveAck,
    output logic [7:0] Dout,
    output logic       Receive,
    output logic       ParityErr,
    output logic       FrameErr,
    output logic       Overrun
);
    localparam int BIT_CYCLES  = CLK_FREQ / BAUD_RATE;
    localparam int HALF_CYCLES = BIT_CYCLES / 2;
    localparam int TW          = $clog2(BIT_CYCLES);
    localparam logic [TW-1:0] HALF_END = TW'(HALF_CYCLES - 1);
    localparam logic [TW-1:0] BIT_END  = TW'(BIT_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, START, BITS, PAR, STOP} state_t;

    state_t        state, next;
    logic          s1, sin_s;
    logic [TW-1:0] timer;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;
    logic          par_bit;
    logic          hit, done;

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) {s1, sin_s} <= 2'b11;
        else        {s1, sin_s} <= {Sin, s1};
    end

    always_comb begin
        next = state;
        hit  = 1'b0;
        done = 1'b0;
        case (state)
            IDLE:  next = sin_s ? IDLE : START;
            START: begin
                hit = timer == HALF_END;
                if (hit) next = sin_s ? IDLE : BITS;
            end
            BITS: begin
                hit = timer == BIT_END;
                if (hit && bit_cnt == 3'd7) next = PAR;
            end
            PAR: begin
                hit = timer == BIT_END;
                if (hit) next = STOP;
            end
            STOP: begin
                hit  = timer == BIT_END;
                done = hit;
                if (hit) next = IDLE;
            end
            default: next = IDLE;
        endcase
    end

    // Every state change happens on a sample or out of IDLE, so this also clears the timer on entry.
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            state   <= IDLE;
            timer   <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
            par_bit <= 1'b0;
        end else begin
            state <= next;
            timer <= (state == IDLE || hit) ? '0 : timer + 1'b1;
            if (state == START && hit) bit_cnt <= '0;
            else if (state == BITS && hit) begin
                shreg[bit_cnt] <= sin_s;
                bit_cnt        <= bit_cnt + 3'd1;
            end
            if (state == PAR && hit) par_bit <= sin_s;
        end
    end

    // Completion outranks a same-cycle acknowledge.
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            Dout      <= 8'h00;
            Receive   <= 1'b0;
            ParityErr <= 1'b0;
            FrameErr  <= 1'b0;
            Overrun   <= 1'b0;
        end else if (done) begin
            Dout      <= shreg;
            ParityErr <= ~(^{shreg, par_bit});
            FrameErr  <= ~sin_s;
            Overrun   <= Receive & ~ReceiveAck;
            Receive   <= 1'b1;
        end else if (ReceiveAck) begin
            Receive <= 1'b0;
        end
    end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: randomized self-checking bench for uart_rx against a frame-level reference model
// (16 clocks per bit).
module tb_uart_rx;
    localparam int BITC = 16;

    logic       clk = 1'b0;
    logic       Reset, Sin, ReceiveAck;
    logic [7:0] Dout;
    logic       Receive, ParityErr, FrameErr, Overrun;

    int checks = 0, errors = 0;
    int cyc = 0, frame_cyc = 0, rise_cyc = -1;
    logic rcv_q = 1'b0;

    logic [7:0] m_dout;
    logic       m_rcv, m_perr, m_ferr, m_ovr;

    uart_rx #(.CLK_FREQ(1600), .BAUD_RATE(100)) dut (
        .clk(clk), .Reset(Reset), .Sin(Sin), .ReceiveAck(ReceiveAck),
        .Dout(Dout), .Receive(Receive), .ParityErr(ParityErr),
        .FrameErr(FrameErr), .Overrun(Overrun)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (Receive && !rcv_q) rise_cyc = cyc;
        rcv_q = Receive;
    end

    function automatic logic odd_parity(input logic [7:0] d);
        return ($countones(d) % 2) == 0;
    endfunction

    task automatic model_reset();
        m_dout = 8'h00; m_rcv = 0; m_perr = 0; m_ferr = 0; m_ovr = 0;
    endtask

    // A completed frame: the 9 data+parity bits must hold an odd count of ones; stop must be 1.
    task automatic model_frame(input logic [7:0] d, input logic p, input logic s);
        m_ovr  = m_rcv;
        m_dout = d;
        m_perr = (($countones(d) + int'(p)) % 2) == 0;
        m_ferr = !s;
        m_rcv  = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic p, input logic s);
        logic [10:0] fr;
        fr = {s, p, d, 1'b0};
        frame_cyc = cyc;
        for (int i = 0; i < 11; i++) begin
            Sin = fr[i];
            repeat (BITC) @(negedge clk);
        end
        Sin = 1'b1;
    endtask

    task automatic ack();
        ReceiveAck = 1'b1;
        @(negedge clk);
        ReceiveAck = 1'b0;
        m_rcv = 1'b0;
    endtask

    task automatic test_reset();
        Reset = 1'b0; Sin = 1'b1; ReceiveAck = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({Dout, Receive, ParityErr, FrameErr, Overrun} !== {m_dout, m_rcv, m_perr, m_ferr, m_ovr}) begin
            errors++;
            $display("FAIL reset_values: got %h exp %h", {Dout, Receive, ParityErr, FrameErr, Overrun},
                     {m_dout, m_rcv, m_perr, m_ferr, m_ovr});
        end
        Reset = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_valid_byte();
        rise_cyc = -1;
        send_frame(8'hA5, odd_parity(8'hA5), 1'b1);
        model_frame(8'hA5, odd_parity(8'hA5), 1'b1);
        repeat (4) @(negedge clk);
        checks++;
        if ({Dout, Receive, ParityErr, FrameErr, Overrun} !== {m_dout, m_rcv, m_perr, m_ferr, m_ovr}) begin
            errors++;
            $display("FAIL valid_byte: got %h exp %h", {Dout, Receive, ParityErr, FrameErr, Overrun},
                     {m_dout, m_rcv, m_perr, m_ferr, m_ovr});
        end
        checks++;
        if (rise_cyc < 0 || rise_cyc - frame_cyc < 2 + 8 + 160 - 1 || rise_cyc - frame_cyc > 2 + 8 + 160 + 1) begin
            errors++;
            $display("FAIL latency: got %0d exp 170+-1", rise_cyc < 0 ? -1 : rise_cyc - frame_cyc);
        end
        ack();
        checks++;
        if (Receive !== m_rcv) begin
            errors++;
            $display("FAIL ack_clears: got %b exp %b", Receive, m_rcv);
        end
        repeat (20) @(negedge clk);
    endtask

    task automatic test_parity_error();
        send_frame(8'h3C, 1'b0, 1'b1);
        model_frame(8'h3C, 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        checks++;
        if ({Dout, Receive, ParityErr, FrameErr, Overrun} !== {m_dout, m_rcv, m_perr, m_ferr, m_ovr}) begin
            errors++;
            $display("FAIL parity_error: got %h exp %h", {Dout, Receive, ParityErr, FrameErr, Overrun},
                     {m_dout, m_rcv, m_perr, m_ferr, m_ovr});
        end
        ack();
        repeat (20) @(negedge clk);
    endtask

    task automatic test_framing_error();
        send_frame(8'h01, odd_parity(8'h01), 1'b0);
        model_frame(8'h01, odd_parity(8'h01), 1'b0);
        repeat (24) @(negedge clk);
        checks++;
        if ({Dout, Receive, ParityErr, FrameErr, Overrun} !== {m_dout, m_rcv, m_perr, m_ferr, m_ovr}) begin
            errors++;
            $display("FAIL framing_error: got %h exp %h", {Dout, Receive, ParityErr, FrameErr, Overrun},
                     {m_dout, m_rcv, m_perr, m_ferr, m_ovr});
        end
        ack();
        repeat (20) @(negedge clk);
    endtask

    task automatic test_glitch();
        Sin = 1'b0;
        repeat (3) @(negedge clk);
        Sin = 1'b1;
        repeat (30) @(negedge clk);
        checks++;
        if (Receive !== m_rcv) begin
            errors++;
            $display("FAIL glitch_no_receive: got %b exp %b", Receive, m_rcv);
        end
        send_frame(8'h5A, odd_parity(8'h5A), 1'b1);
        model_frame(8'h5A, odd_parity(8'h5A), 1'b1);
        repeat (4) @(negedge clk);
        checks++;
        if ({Dout, Receive, ParityErr, FrameErr, Overrun} !== {m_dout, m_rcv, m_perr, m_ferr, m_ovr}) begin
            errors++;
            $display("FAIL after_glitch: got %h exp %h", {Dout, Receive, ParityErr, FrameErr, Overrun},
                     {m_dout, m_rcv, m_perr, m_ferr, m_ovr});
        end
        ack();
        repeat (20) @(negedge clk);
    endtask

    task automatic test_back_to_back();
        send_frame(8'h11, odd_parity(8'h11), 1'b1);
        model_frame(8'h11, odd_parity(8'h11), 1'b1);
        send_frame(8'h22, odd_parity(8'h22), 1'b1);
        model_frame(8'h22, odd_parity(8'h22), 1'b1);
        repeat (4) @(negedge clk);
        checks++;
        if ({Dout, Receive, ParityErr, FrameErr, Overrun} !== {m_dout, m_rcv, m_perr, m_ferr, m_ovr}) begin
            errors++;
            $display("FAIL overrun: got %h exp %h", {Dout, Receive, ParityErr, FrameErr, Overrun},
                     {m_dout, m_rcv, m_perr, m_ferr, m_ovr});
        end
        ack();
        checks++;
        if ({Receive, Overrun} !== {m_rcv, m_ovr}) begin
            errors++;
            $display("FAIL overrun_sticky: got %b exp %b", {Receive, Overrun}, {m_rcv, m_ovr});
        end
        repeat (20) @(negedge clk);
        send_frame(8'h33, odd_parity(8'h33), 1'b1);
        model_frame(8'h33, odd_parity(8'h33), 1'b1);
        repeat (4) @(negedge clk);
        checks++;
        if ({Dout, Receive, ParityErr, FrameErr, Overrun} !== {m_dout, m_rcv, m_perr, m_ferr, m_ovr}) begin
            errors++;
            $display("FAIL overrun_clear: got %h exp %h", {Dout, Receive, ParityErr, FrameErr, Overrun},
                     {m_dout, m_rcv, m_perr, m_ferr, m_ovr});
        end
        repeat (20) @(negedge clk);
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] d;
        d = 8'h5C;
        Sin = 1'b0;
        repeat (BITC) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            Sin = d[i];
            repeat (BITC) @(negedge clk);
        end
        Sin = d[4];
        repeat (BITC / 2) @(negedge clk);
        Reset = 1'b0;
        model_reset();
        #1;
        checks++;
        if ({Dout, Receive, ParityErr, FrameErr, Overrun} !== {m_dout, m_rcv, m_perr, m_ferr, m_ovr}) begin
            errors++;
            $display("FAIL reset_mid_frame: got %h exp %h", {Dout, Receive, ParityErr, FrameErr, Overrun},
                     {m_dout, m_rcv, m_perr, m_ferr, m_ovr});
        end
        @(negedge clk);
        Sin = 1'b1;
        repeat (3) @(negedge clk);
        Reset = 1'b1;
        repeat (BITC * 8) @(negedge clk);
        checks++;
        if (Receive !== m_rcv) begin
            errors++;
            $display("FAIL aborted_frame_silent: got %b exp %b", Receive, m_rcv);
        end
        send_frame(8'hFF, odd_parity(8'hFF), 1'b1);
        model_frame(8'hFF, odd_parity(8'hFF), 1'b1);
        repeat (4) @(negedge clk);
        checks++;
        if ({Dout, Receive, ParityErr, FrameErr, Overrun} !== {m_dout, m_rcv, m_perr, m_ferr, m_ovr}) begin
            errors++;
            $display("FAIL after_reset_ff: got %h exp %h", {Dout, Receive, ParityErr, FrameErr, Overrun},
                     {m_dout, m_rcv, m_perr, m_ferr, m_ovr});
        end
        ack();
        repeat (20) @(negedge clk);
    endtask

    task automatic test_random();
        logic [7:0] d;
        logic       p, s;
        for (int n = 0; n < 12; n++) begin
            d = 8'($urandom);
            p = odd_parity(d) ^ ($urandom_range(0, 3) == 0);
            s = $urandom_range(0, 3) != 0;
            send_frame(d, p, s);
            model_frame(d, p, s);
            repeat (24) @(negedge clk);
            checks++;
            if ({Dout, Receive, ParityErr, FrameErr, Overrun} !== {m_dout, m_rcv, m_perr, m_ferr, m_ovr}) begin
                errors++;
                $display("FAIL random_%0d: got %h exp %h", n, {Dout, Receive, ParityErr, FrameErr, Overrun},
                         {m_dout, m_rcv, m_perr, m_ferr, m_ovr});
            end
            if ($urandom_range(0, 1) == 1) begin
                ack();
                checks++;
                if (Receive !== m_rcv) begin
                    errors++;
                    $display("FAIL random_ack_%0d: got %b exp %b", n, Receive, m_rcv);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_valid_byte();
        test_parity_error();
        test_framing_error();
        test_glitch();
        test_back_to_back();
        test_reset_mid_frame();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receiver; sits directly downstream of the tx block and consumes its serial stream on the board or loopback link.
- Frame format is fixed: 1 start bit (0), 8 data bits LSB first, 1 odd-parity bit, 1 stop bit (1).
- Samples each bit at mid-period. Presents the received byte with a level-held Receive/ReceiveAck handshake, plus parity, framing and overrun status.

Parameters:
- CLK_FREQ, 100_000_000, system clock frequency in Hz.
- BAUD_RATE, 19_200, line bit rate in bits/s.
- BIT_CYCLES, CLK_FREQ/BAUD_RATE, clocks per bit (derived localparam, must be >= 4).
- HALF_CYCLES, BIT_CYCLES/2, clocks from detected start edge to start-bit sample (derived localparam).

Ports:
- clk  in  1  system clock.
- Reset  in  1  asynchronous, active-low reset (0 = reset).
- Sin  in  1  asynchronous serial input, idles high.
- ReceiveAck  in  1  consumer acknowledge; clears Receive.
- Dout  out  8  last received data byte.
- Receive  out  1  byte available; level signal, held until acknowledged.
- ParityErr  out  1  parity status of the byte in Dout.
- FrameErr  out  1  stop bit was sampled as 0 for the byte in Dout.
- Overrun  out  1  a frame completed while Receive was still 1.

Behaviour:
- Synchronizer:
  - Sin passes through 2 flops to give sin_s; all decisions use sin_s.
  - Both synchronizer flops reset to 1.
- Reset (asynchronous, Reset=0):
  - State returns to IDLE; timer and bit counter cleared.
  - Dout=8'h00, Receive=0, ParityErr=0, FrameErr=0, Overrun=0.
  - Reset asserted mid-frame aborts the frame with no output update.
- Timer: counts clocks within the current bit; cleared on every state entry and after every sample.
- Bit counter: 3 bits, 0..7, indexes the data bit being sampled.
- FSM states: IDLE, START, BITS, PAR, STOP.
  - IDLE: timer held clear. sin_s=0 -> START.
  - START: at timer = HALF_CYCLES-1, sample sin_s. If 1 (glitch / false start) -> IDLE with no outputs changed. If 0 -> BITS, with timer and bit counter cleared.
  - BITS: at timer = BIT_CYCLES-1, shift sin_s into shift register bit [bitcount]. If bitcount=7 -> PAR, else increment bitcount.
  - PAR: at timer = BIT_CYCLES-1, capture parity bit -> STOP.
  - STOP: at timer = BIT_CYCLES-1 (mid stop bit), perform the completion update, then -> IDLE in the same cycle, so a back-to-back start edge half a bit later is detected.
- Completion update (the STOP sample clock edge):
  - Dout <= shift register.
  - ParityErr <= ~(^{data, parity_bit}). The 9 bits must contain an odd number of ones.
  - FrameErr <= ~sin_s.
  - Overrun <= Receive & ~ReceiveAck.
  - Receive <= 1.
- Handshake:
  - ReceiveAck=1 while Receive=1 -> Receive=0 next clock.
  - ReceiveAck while Receive=0 has no effect.
  - Completion and ReceiveAck in the same cycle: completion wins (Receive stays 1), and Overrun=0 for that byte.
  - Overrun is sticky until the next completion that is not an overrun, or until reset. Dout is always overwritten with the newest byte.
- Latency: Receive rises 2 + HALF_CYCLES + 10*BIT_CYCLES (±1) clocks after the Sin falling edge.
- Errored frames still assert Receive; the consumer decides what to discard.
- Line held low forever: a frame error is reported, then IDLE re-enters START immediately and retriggers. This is acceptable and documented.

Test Plan (CLK_FREQ=1600, BAUD_RATE=100, so BIT_CYCLES=16):
1. Valid byte: drive 0xA5 frame (data LSB first, parity=1, stop=1) -> Receive=1 within 2+8+160±1 clocks, Dout=8'hA5, ParityErr=0, FrameErr=0; pulse ReceiveAck -> Receive=0 next clock.
2. Parity error: 0x3C with parity bit 0 -> Dout=8'h3C, ParityErr=1, FrameErr=0, Receive=1.
3. Framing error: 0x01 with correct parity and stop bit=0 -> Dout=8'h01, FrameErr=1, Receive=1.
4. Glitch rejection: Sin low for 3 clocks, then high -> Receive stays 0, FSM back in IDLE; a following valid 0x5A frame is received correctly.
5. Overrun and back-to-back: send 0x11 then 0x22 with no ReceiveAck and stop bits of exactly 1 bit -> Dout=8'h22, Overrun=1; after ack, send 0x33 -> Overrun=0.
6. Reset mid-frame: assert Reset=0 during data bit 4 -> outputs at reset values immediately; after release, a 0xFF frame gives Dout=8'hFF, ParityErr=0.
